// File: rtl/adder_result_accum.sv
// Result accumulator behind the pipelined 8-bit adder: groups ACC_N results into
// blocks (saturating sum plus maximum) and hands them out through a 2-entry FIFO.
module adder_result_accum #(
    parameter int ADD_LAT = 2,
    parameter int ACC_N   = 8,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_vld,
    input  logic [7:0]       add_dout,
    input  logic             add_cout,
    output logic [ACC_W-1:0] res_sum,
    output logic [8:0]       res_max,
    output logic             res_sat,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             drop_err,
    output logic             busy
);

    localparam int CNT_W = (ACC_N > 1) ? $clog2(ACC_N) : 1;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [8:0]       mx;
        logic             sat;
    } entry_t;

    logic [ADD_LAT-1:0] v;
    logic [ACC_W-1:0]   acc;
    logic [8:0]         mx;
    logic               sat;
    logic [CNT_W-1:0]   cnt;

    logic               sample;
    logic [8:0]         val;
    logic [ACC_W:0]     ext;
    logic               ovf;
    logic [ACC_W-1:0]   acc_nxt;
    logic [8:0]         mx_nxt;
    logic               last;

    entry_t             mem [2];
    entry_t             head;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fcnt;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;

    // The extra top bit of ext catches the single possible carry out of acc.
    always_comb begin
        sample  = v[ADD_LAT-1];
        val     = {add_cout, add_dout};
        ext     = {1'b0, acc} + {{(ACC_W-8){1'b0}}, val};
        ovf     = ext[ACC_W];
        acc_nxt = ovf ? '1 : ext[ACC_W-1:0];
        mx_nxt  = (val > mx) ? val : mx;
        last    = sample && (cnt == CNT_W'(ACC_N - 1));
        push    = last;
        full    = (fcnt == 2'd2);
        pop     = res_vld && res_rdy;
        wr_en   = push && (!full || pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            v        <= '0;
            acc      <= '0;
            mx       <= '0;
            sat      <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fcnt     <= 2'd0;
            drop_err <= 1'b0;
        end else begin
            v[0] <= in_vld;
            for (int i = 1; i < ADD_LAT; i++) begin
                v[i] <= v[i-1];
            end

            if (sample) begin
                if (last) begin
                    acc <= '0;
                    mx  <= '0;
                    sat <= 1'b0;
                    cnt <= '0;
                end else begin
                    acc <= acc_nxt;
                    mx  <= mx_nxt;
                    sat <= sat | ovf;
                    cnt <= cnt + 1'b1;
                end
            end

            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            if (wr_en && !pop)      fcnt <= fcnt + 2'd1;
            else if (!wr_en && pop) fcnt <= fcnt - 2'd1;

            if (push && full && !pop) drop_err <= 1'b1;
        end
    end

    // NOTE: FIFO storage carries no reset; the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{sum: acc_nxt, mx: mx_nxt, sat: sat | ovf};
        end
    end

    always_comb begin
        head    = mem[rd_ptr];
        res_vld = (fcnt != 2'd0);
        res_sum = res_vld ? head.sum : '0;
        res_max = res_vld ? head.mx  : '0;
        res_sat = res_vld ? head.sat : 1'b0;
        busy    = (|v) || (cnt != '0);
    end

endmodule

// File: tb/tb_adder_result_accum.sv
// Directed bench for adder_result_accum: a behavioural adder pipeline feeds a
// default instance and a narrow saturating instance (ACC_W=12, ACC_N=9).
module tb_adder_result_accum;

    localparam int ADD_LAT = 2;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [7:0]  din_1 = '0;
    logic [7:0]  din_2 = '0;
    logic        cin = 1'b0;
    logic [8:0]  pipe [ADD_LAT];
    logic [7:0]  add_dout;
    logic        add_cout;

    logic        in_vld = 1'b0;
    logic        res_rdy = 1'b0;
    logic [15:0] res_sum;
    logic [8:0]  res_max;
    logic        res_sat, res_vld, drop_err, busy;

    logic        in_vld_s = 1'b0;
    logic        res_rdy_s = 1'b0;
    logic [11:0] res_sum_s;
    logic [8:0]  res_max_s;
    logic        res_sat_s, res_vld_s, drop_err_s, busy_s;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Adder model: operands sampled at edge k appear at the output before edge k+ADD_LAT.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, din_1} + {1'b0, din_2} + {8'b0, cin};
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {add_cout, add_dout} = pipe[ADD_LAT-1];

    adder_result_accum #(.ADD_LAT(ADD_LAT), .ACC_N(8), .ACC_W(16)) u_dut (
        .clk(clk), .srst(srst), .in_vld(in_vld), .add_dout(add_dout), .add_cout(add_cout),
        .res_sum(res_sum), .res_max(res_max), .res_sat(res_sat), .res_vld(res_vld),
        .res_rdy(res_rdy), .drop_err(drop_err), .busy(busy)
    );

    adder_result_accum #(.ADD_LAT(ADD_LAT), .ACC_N(9), .ACC_W(12)) u_sat (
        .clk(clk), .srst(srst), .in_vld(in_vld_s), .add_dout(add_dout), .add_cout(add_cout),
        .res_sum(res_sum_s), .res_max(res_max_s), .res_sat(res_sat_s), .res_vld(res_vld_s),
        .res_rdy(res_rdy_s), .drop_err(drop_err_s), .busy(busy_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic [7:0] a, input logic [7:0] b, input logic c);
        for (int i = 0; i < n; i++) begin
            in_vld = 1'b1; din_1 = a; din_2 = b; cin = c;
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic pulse_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; in_vld = 1'b1; din_1 = 8'd5; din_2 = 8'd5;
        repeat (3) tick();
        if (res_sum !== 16'd0) begin $display("FAIL reset_sum: got %0d want 0", res_sum); nerr++; end nvec++;
        if (res_max !== 9'd0)  begin $display("FAIL reset_max: got %0d want 0", res_max); nerr++; end nvec++;
        if (res_sat !== 1'b0)  begin $display("FAIL reset_sat: got %b want 0", res_sat); nerr++; end nvec++;
        if (res_vld !== 1'b0)  begin $display("FAIL reset_vld: got %b want 0", res_vld); nerr++; end nvec++;
        if (drop_err !== 1'b0) begin $display("FAIL reset_drop: got %b want 0", drop_err); nerr++; end nvec++;
        if (busy !== 1'b0)     begin $display("FAIL reset_busy: got %b want 0", busy); nerr++; end nvec++;
        srst = 1'b0; in_vld = 1'b0;
        repeat (3) tick();
        if (busy !== 1'b0) begin $display("FAIL reset_leak_busy: got %b want 0", busy); nerr++; end nvec++;
        // Seven samples after reset must leave an incomplete block.
        send(7, 8'd1, 8'd1, 1'b0);
        repeat (4) tick();
        if (res_vld !== 1'b0) begin $display("FAIL reset_partial_vld: got %b want 0", res_vld); nerr++; end nvec++;
        if (busy !== 1'b1)    begin $display("FAIL reset_partial_busy: got %b want 1", busy); nerr++; end nvec++;
        send(1, 8'd1, 8'd1, 1'b0);
        repeat (ADD_LAT) tick();
        if (res_vld !== 1'b1)  begin $display("FAIL reset_block_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd16) begin $display("FAIL reset_block_sum: got %0d want 16", res_sum); nerr++; end nvec++;
        res_rdy = 1'b1; tick(); res_rdy = 1'b0;
        if (res_vld !== 1'b0) begin $display("FAIL reset_pop_vld: got %b want 0", res_vld); nerr++; end nvec++;
    endtask

    task automatic test_defaults();
        for (int i = 0; i < 8; i++) begin
            in_vld = 1'b1; din_1 = 8'(i); din_2 = 8'(10 + i); cin = 1'b0;
            tick();
        end
        in_vld = 1'b0;
        repeat (ADD_LAT - 1) tick();
        if (res_vld !== 1'b0) begin $display("FAIL defaults_early_vld: got %b want 0", res_vld); nerr++; end nvec++;
        tick();
        if (res_vld !== 1'b1)   begin $display("FAIL defaults_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd136) begin $display("FAIL defaults_sum: got %0d want 136", res_sum); nerr++; end nvec++;
        if (res_max !== 9'd24)  begin $display("FAIL defaults_max: got %0d want 24", res_max); nerr++; end nvec++;
        if (res_sat !== 1'b0)   begin $display("FAIL defaults_sat: got %b want 0", res_sat); nerr++; end nvec++;
        if (busy !== 1'b0)      begin $display("FAIL defaults_busy: got %b want 0", busy); nerr++; end nvec++;
        res_rdy = 1'b1; tick(); res_rdy = 1'b0;
        if (res_vld !== 1'b0) begin $display("FAIL defaults_pop: got %b want 0", res_vld); nerr++; end nvec++;
    endtask

    task automatic test_carry();
        send(8, 8'd200, 8'd100, 1'b1);
        repeat (ADD_LAT) tick();
        if (res_vld !== 1'b1)    begin $display("FAIL carry_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd2408) begin $display("FAIL carry_sum: got %0d want 2408", res_sum); nerr++; end nvec++;
        if (res_max !== 9'd301)  begin $display("FAIL carry_max: got %0d want 301", res_max); nerr++; end nvec++;
        res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            in_vld_s = 1'b1; din_1 = 8'd255; din_2 = 8'd255; cin = 1'b1;
            tick();
        end
        in_vld_s = 1'b0;
        repeat (ADD_LAT) tick();
        if (res_vld_s !== 1'b1)     begin $display("FAIL sat_vld: got %b want 1", res_vld_s); nerr++; end nvec++;
        if (res_sum_s !== 12'd4095) begin $display("FAIL sat_sum: got %0d want 4095", res_sum_s); nerr++; end nvec++;
        if (res_sat_s !== 1'b1)     begin $display("FAIL sat_flag: got %b want 1", res_sat_s); nerr++; end nvec++;
        if (res_max_s !== 9'd511)   begin $display("FAIL sat_max: got %0d want 511", res_max_s); nerr++; end nvec++;
        if (busy_s !== 1'b0)        begin $display("FAIL sat_busy: got %b want 0", busy_s); nerr++; end nvec++;
        if (drop_err_s !== 1'b0)    begin $display("FAIL sat_drop: got %b want 0", drop_err_s); nerr++; end nvec++;
        res_rdy_s = 1'b1; tick(); res_rdy_s = 1'b0;
        if (res_vld_s !== 1'b0) begin $display("FAIL sat_pop: got %b want 0", res_vld_s); nerr++; end nvec++;
    endtask

    task automatic test_backpressure();
        send(8, 8'd1, 8'd0, 1'b0);
        send(8, 8'd2, 8'd0, 1'b0);
        send(8, 8'd3, 8'd0, 1'b0);
        repeat (ADD_LAT + 2) tick();
        if (drop_err !== 1'b1)  begin $display("FAIL bp_drop: got %b want 1", drop_err); nerr++; end nvec++;
        if (res_vld !== 1'b1)   begin $display("FAIL bp_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd8)  begin $display("FAIL bp_head_sum: got %0d want 8", res_sum); nerr++; end nvec++;
        if (res_max !== 9'd1)   begin $display("FAIL bp_head_max: got %0d want 1", res_max); nerr++; end nvec++;
        res_rdy = 1'b1; tick();
        if (res_vld !== 1'b1)   begin $display("FAIL bp_pop1_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd16) begin $display("FAIL bp_pop1_sum: got %0d want 16", res_sum); nerr++; end nvec++;
        tick(); res_rdy = 1'b0;
        if (res_vld !== 1'b0)   begin $display("FAIL bp_pop2_vld: got %b want 0", res_vld); nerr++; end nvec++;
        if (drop_err !== 1'b1)  begin $display("FAIL bp_drop_sticky: got %b want 1", drop_err); nerr++; end nvec++;
        pulse_reset();
        if (drop_err !== 1'b0)  begin $display("FAIL bp_drop_clear: got %b want 0", drop_err); nerr++; end nvec++;
    endtask

    task automatic test_push_pop_full();
        send(8, 8'd1, 8'd0, 1'b0);
        send(8, 8'd2, 8'd0, 1'b0);
        send(8, 8'd3, 8'd0, 1'b0);
        repeat (ADD_LAT - 1) tick();
        if (res_sum !== 16'd8) begin $display("FAIL ppf_pre_sum: got %0d want 8", res_sum); nerr++; end nvec++;
        // Pop lands on the same edge as the third block's push.
        res_rdy = 1'b1; tick(); res_rdy = 1'b0;
        if (drop_err !== 1'b0)  begin $display("FAIL ppf_drop: got %b want 0", drop_err); nerr++; end nvec++;
        if (res_vld !== 1'b1)   begin $display("FAIL ppf_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd16) begin $display("FAIL ppf_head2: got %0d want 16", res_sum); nerr++; end nvec++;
        res_rdy = 1'b1; tick();
        if (res_sum !== 16'd24) begin $display("FAIL ppf_head3: got %0d want 24", res_sum); nerr++; end nvec++;
        tick(); res_rdy = 1'b0;
        if (res_vld !== 1'b0)   begin $display("FAIL ppf_empty: got %b want 0", res_vld); nerr++; end nvec++;
    endtask

    task automatic test_mid_reset();
        send(5, 8'd100, 8'd100, 1'b0);
        pulse_reset();
        if (busy !== 1'b0)    begin $display("FAIL mid_busy: got %b want 0", busy); nerr++; end nvec++;
        if (res_vld !== 1'b0) begin $display("FAIL mid_vld: got %b want 0", res_vld); nerr++; end nvec++;
        for (int i = 0; i < 8; i++) begin
            in_vld = 1'b1; din_1 = 8'(i); din_2 = 8'(10 + i); cin = 1'b0;
            tick();
        end
        in_vld = 1'b0;
        repeat (ADD_LAT) tick();
        if (res_vld !== 1'b1)    begin $display("FAIL mid_block_vld: got %b want 1", res_vld); nerr++; end nvec++;
        if (res_sum !== 16'd136) begin $display("FAIL mid_block_sum: got %0d want 136", res_sum); nerr++; end nvec++;
        if (res_max !== 9'd24)   begin $display("FAIL mid_block_max: got %0d want 24", res_max); nerr++; end nvec++;
        res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_carry();
        test_saturation();
        test_backpressure();
        test_push_pop_full();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
